// File: rtl/b2b_event_merger.sv
// b2b_event_merger: receive end of the board-to-board link.
// Drains TOTAL_INPUT_BOARDS FWFT FIFOs and merges whole events round-robin into one
// output FIFO stream, never interleaving words of two events.
// Optional feature macro: B2B_MERGE_TIMEOUT_EN closes a starved event with a synthetic
// footer after TIMEOUT_CYCLES stalled cycles.
module b2b_event_merger #(
   parameter int unsigned DATA_WIDTH         = 65,
   parameter int unsigned TOTAL_INPUT_BOARDS = 14,
   parameter int unsigned HDR_WORDS          = 1,
   parameter int unsigned CNT_WIDTH          = 32,
   parameter int unsigned TIMEOUT_CYCLES     = 1024
) (
   input  logic                                          b2b_clk,
   input  logic                                          b2b_srst,
   input  logic [TOTAL_INPUT_BOARDS-1:0][DATA_WIDTH-1:0] in_data,
   input  logic [TOTAL_INPUT_BOARDS-1:0]                 in_empty,
   output logic [TOTAL_INPUT_BOARDS-1:0]                 in_ren,
   output logic [DATA_WIDTH-1:0]                         out_data,
   output logic                                          out_wren,
   input  logic                                          out_almost_full,
   output logic [CNT_WIDTH-1:0]                          events_merged,
   output logic [CNT_WIDTH-1:0]                          proto_err_cnt,
   output logic                                          busy
);

   localparam int unsigned SelW = (TOTAL_INPUT_BOARDS > 1) ? $clog2(TOTAL_INPUT_BOARDS) : 1;
   localparam int unsigned HdrW = (HDR_WORDS > 1) ? $clog2(HDR_WORDS) : 1;
   localparam logic [SelW-1:0] LastBoard = SelW'(TOTAL_INPUT_BOARDS - 1);
   localparam logic [HdrW-1:0] LastHdr   = HdrW'(HDR_WORDS - 1);

   typedef enum logic [1:0] {StIdle, StHeader, StBody} state_e;

   state_e                  state_q;
   logic [SelW-1:0]         sel_q;
   logic [SelW-1:0]         rr_ptr_q;
   logic [HdrW-1:0]         hdr_cnt_q;

   logic                    found;
   logic [SelW-1:0]         cand;
   logic                    cand_meta;
   logic                    sel_empty;
   logic [DATA_WIDTH-1:0]   sel_word;
   logic                    sel_meta;
   logic [SelW-1:0]         sel_next;
   logic                    pop;
   logic                    orphan_pop;
   logic                    ev_inc;
   logic                    err_inc;
   logic                    timeout_fire;
   logic [DATA_WIDTH-1:0]   timeout_word;

   function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   assign busy      = (state_q != StIdle);
   assign cand_meta = in_data[cand][DATA_WIDTH-1];
   assign sel_empty = in_empty[sel_q];
   assign sel_word  = in_data[sel_q];
   assign sel_meta  = sel_word[DATA_WIDTH-1];
   assign sel_next  = (sel_q == LastBoard) ? '0 : sel_q + 1'b1;

   // Round-robin search: first non-empty board starting at rr_ptr, wrapping modulo N.
   always_comb begin
      logic [SelW:0] idx;
      found = 1'b0;
      cand  = rr_ptr_q;
      idx   = '0;
      for (int unsigned i = 0; i < TOTAL_INPUT_BOARDS; i++) begin
         idx = {1'b0, rr_ptr_q} + (SelW+1)'(i);
         if (idx >= (SelW+1)'(TOTAL_INPUT_BOARDS)) begin
            idx = idx - (SelW+1)'(TOTAL_INPUT_BOARDS);
         end
         if (!found && !in_empty[idx[SelW-1:0]]) begin
            found = 1'b1;
            cand  = idx[SelW-1:0];
         end
      end
   end

   // Pop control: drop an orphan while idle, otherwise pop only the locked board.
   always_comb begin
      in_ren     = '0;
      pop        = 1'b0;
      orphan_pop = 1'b0;
      if (!b2b_srst) begin
         if (state_q == StIdle) begin
            if (found && !cand_meta) begin
               in_ren[cand] = 1'b1;
               orphan_pop   = 1'b1;
            end
         end else if (!sel_empty && !out_almost_full) begin
            in_ren[sel_q] = 1'b1;
            pop           = 1'b1;
         end
      end
   end

   // Counter events: footers (real or synthetic) and protocol errors.
   always_comb begin
      ev_inc  = ((state_q == StBody) && pop && sel_meta) || timeout_fire;
      err_inc = orphan_pop || ((state_q == StHeader) && pop && !sel_meta) || timeout_fire;
   end

`ifdef B2B_MERGE_TIMEOUT_EN
   localparam int unsigned   StallW     = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [StallW-1:0] StallLimit = StallW'(TIMEOUT_CYCLES);

   logic [StallW-1:0] stall_q;

   assign timeout_word = {1'b1, 8'hEE, {(DATA_WIDTH-9){1'b0}}};
   assign timeout_fire = busy && sel_empty && !out_almost_full && (stall_q == StallLimit);

   // Stall counter: runs while the locked board is empty; any pop or unlock clears it.
   always_ff @(posedge b2b_clk) begin
      if (b2b_srst || !busy || pop || timeout_fire) begin
         stall_q <= '0;
      end else if (sel_empty && (stall_q != StallLimit)) begin
         stall_q <= stall_q + 1'b1;
      end
   end
`else
   logic unused_timeout_cfg;

   assign timeout_word       = '0;
   assign timeout_fire       = 1'b0;
   assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

   // Arbitration FSM with registered write port and saturating counters.
   always_ff @(posedge b2b_clk) begin
      if (b2b_srst) begin
         state_q       <= StIdle;
         sel_q         <= '0;
         rr_ptr_q      <= '0;
         hdr_cnt_q     <= '0;
         out_data      <= '0;
         out_wren      <= 1'b0;
         events_merged <= '0;
         proto_err_cnt <= '0;
      end else begin
         out_wren <= pop | timeout_fire;
         if (pop) begin
            out_data <= sel_word;
         end else if (timeout_fire) begin
            out_data <= timeout_word;
         end
         if (ev_inc) begin
            events_merged <= sat_inc(events_merged);
         end
         if (err_inc) begin
            proto_err_cnt <= sat_inc(proto_err_cnt);
         end
         unique case (state_q)
            StIdle: begin
               if (found && !orphan_pop) begin
                  sel_q     <= cand;
                  hdr_cnt_q <= '0;
                  state_q   <= StHeader;
               end
            end
            StHeader: begin
               if (timeout_fire) begin
                  state_q  <= StIdle;
                  rr_ptr_q <= sel_next;
               end else if (pop) begin
                  if (hdr_cnt_q == LastHdr) begin
                     state_q <= StBody;
                  end else begin
                     hdr_cnt_q <= hdr_cnt_q + 1'b1;
                  end
               end
            end
            StBody: begin
               if (ev_inc) begin
                  state_q  <= StIdle;
                  rr_ptr_q <= sel_next;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_b2b_event_merger.sv
// tb_b2b_event_merger: directed table-driven bench for b2b_event_merger with per-board
// FWFT FIFO models and a captured output stream.
module tb_b2b_event_merger;

   localparam int DW = 65;
   localparam int NB = 14;
   localparam int CW = 32;
   localparam int NV = 4;

   logic                   clk = 1'b0;
   logic                   srst;
   logic [NB-1:0][DW-1:0]  in_data;
   logic [NB-1:0]          in_empty;
   logic [NB-1:0]          in_ren;
   logic [DW-1:0]          out_data;
   logic                   out_wren;
   logic                   afull;
   logic [CW-1:0]          events_merged;
   logic [CW-1:0]          proto_err_cnt;
   logic                   busy;

   always #5 clk = ~clk;

   b2b_event_merger #(
      .DATA_WIDTH         (DW),
      .TOTAL_INPUT_BOARDS (NB),
      .HDR_WORDS          (1),
      .CNT_WIDTH          (CW),
      .TIMEOUT_CYCLES     (16)
   ) dut (
      .b2b_clk         (clk),
      .b2b_srst        (srst),
      .in_data         (in_data),
      .in_empty        (in_empty),
      .in_ren          (in_ren),
      .out_data        (out_data),
      .out_wren        (out_wren),
      .out_almost_full (afull),
      .events_merged   (events_merged),
      .proto_err_cnt   (proto_err_cnt),
      .busy            (busy)
   );

   typedef struct {
      int                  board;
      int                  nw;
      logic [5:0][DW-1:0]  w;
      int                  nexp;
      logic [5:0][DW-1:0]  e;
      int                  err_inc;
   } vec_t;

   vec_t          vt [NV];
   int            checks = 0;
   int            errors = 0;
   logic [DW-1:0] mem [NB][32];
   int            rd [NB];
   int            wr [NB];
   logic [NB-1:0] hold;
   logic [DW-1:0] outw [128];
   int            nout;
   int            cyc;
   logic [NB-1:0] ren_s;
   int            ren_viol;
   bit            lat_mon;
   int            lat_err;
   int            lat_pops;
   int            first_pop [NB];
   int            last_pop [NB];
   int            exp_ev;
   int            exp_err;
   int            bp_viol;

   function automatic logic [DW-1:0] w(input bit m, input logic [63:0] v);
      return {m, v};
   endfunction

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive();
      for (int b = 0; b < NB; b++) begin
         in_empty[b] = (rd[b] == wr[b]) || hold[b];
         in_data[b]  = (rd[b] != wr[b]) ? mem[b][rd[b]] : '0;
      end
   endtask

   task automatic push(input int b, input logic [DW-1:0] word);
      mem[b][wr[b]] = word;
      wr[b]++;
   endtask

   task automatic clear_fifos();
      for (int b = 0; b < NB; b++) begin
         rd[b]        = 0;
         wr[b]        = 0;
         first_pop[b] = -1;
         last_pop[b]  = -1;
      end
   endtask

   function automatic bit fifos_empty();
      for (int b = 0; b < NB; b++) begin
         if (rd[b] != wr[b]) return 1'b0;
      end
      return 1'b1;
   endfunction

   // One clock: sample pops before the edge, apply them and capture writes after it.
   task automatic step();
      logic [DW-1:0] popped;
      @(negedge clk);
      ren_s  = in_ren;
      popped = '0;
      if ((ren_s & (ren_s - 1'b1)) != '0) ren_viol++;
      @(posedge clk);
      #1;
      for (int b = 0; b < NB; b++) begin
         if (ren_s[b]) begin
            if (rd[b] == wr[b] || hold[b]) begin
               ren_viol++;
            end else begin
               popped = mem[b][rd[b]];
               rd[b]++;
               if (first_pop[b] < 0) first_pop[b] = cyc;
               last_pop[b] = cyc;
            end
         end
      end
      cyc++;
      if (out_wren && nout < 128) begin
         outw[nout] = out_data;
         nout++;
      end
      if (lat_mon) begin
         if (ren_s != '0) begin
            lat_pops++;
            if (!out_wren || out_data !== popped) lat_err++;
         end else if (out_wren) begin
            lat_err++;
         end
      end
      drive();
   endtask

   task automatic run_idle(input string name);
      int n;
      bit done;
      n    = 0;
      done = 1'b0;
      while (!done) begin
         step();
         n++;
         done = fifos_empty() && !busy && !out_wren;
         if (!done && n > 200) begin
            checks++;
            errors++;
            $display("FAIL %s: no completion within 200 cycles (busy=%0b)", name, busy);
            done = 1'b1;
         end
      end
   endtask

   task automatic do_reset();
      srst = 1'b1;
      step();
      step();
      srst = 1'b0;
      exp_ev  = 0;
      exp_err = 0;
   endtask

   task automatic chk_counters(input string name);
      chk({name, " events"}, events_merged, exp_ev);
      chk({name, " errs"}, proto_err_cnt, exp_err);
   endtask

   initial begin
      // Table: one event per record, orphans expected to be dropped.
      vt[0].board = 3;  vt[0].nw = 4;  vt[0].nexp = 4; vt[0].err_inc = 0;
      vt[0].w[0] = w(1, 'hA); vt[0].w[1] = w(0, 'h1); vt[0].w[2] = w(0, 'h2);
      vt[0].w[3] = w(1, 'hF);
      vt[0].e[0] = w(1, 'hA); vt[0].e[1] = w(0, 'h1); vt[0].e[2] = w(0, 'h2);
      vt[0].e[3] = w(1, 'hF);

      vt[1].board = 5;  vt[1].nw = 4;  vt[1].nexp = 3; vt[1].err_inc = 1;
      vt[1].w[0] = w(0, 'h55); vt[1].w[1] = w(1, 'hB); vt[1].w[2] = w(0, 'h7);
      vt[1].w[3] = w(1, 'hC);
      vt[1].e[0] = w(1, 'hB); vt[1].e[1] = w(0, 'h7); vt[1].e[2] = w(1, 'hC);

      vt[2].board = 13; vt[2].nw = 2;  vt[2].nexp = 2; vt[2].err_inc = 0;
      vt[2].w[0] = w(1, 'h13); vt[2].w[1] = w(1, 'h31);
      vt[2].e[0] = w(1, 'h13); vt[2].e[1] = w(1, 'h31);

      vt[3].board = 7;  vt[3].nw = 6;  vt[3].nexp = 4; vt[3].err_inc = 2;
      vt[3].w[0] = w(0, 'h1);  vt[3].w[1] = w(0, 'h2);  vt[3].w[2] = w(1, 'h70);
      vt[3].w[3] = w(0, 'h71); vt[3].w[4] = w(0, 'h72); vt[3].w[5] = w(1, 'h7F);
      vt[3].e[0] = w(1, 'h70); vt[3].e[1] = w(0, 'h71); vt[3].e[2] = w(0, 'h72);
      vt[3].e[3] = w(1, 'h7F);

      afull    = 1'b0;
      hold     = '0;
      nout     = 0;
      cyc      = 0;
      ren_viol = 0;
      lat_mon  = 1'b0;
      lat_err  = 0;
      lat_pops = 0;
      bp_viol  = 0;
      clear_fifos();
      drive();

      // Reset state
      do_reset();
      chk("rst wren", out_wren, 0);
      chk("rst data", out_data, 0);
      chk("rst busy", busy, 0);
      chk("rst ren", in_ren, 0);
      chk_counters("rst");

      // Table-driven single events
      for (int i = 0; i < NV; i++) begin
         nout = 0;
         for (int k = 0; k < vt[i].nw; k++) push(vt[i].board, vt[i].w[k]);
         drive();
         run_idle($sformatf("vec%0d", i));
         exp_ev  = exp_ev + 1;
         exp_err = exp_err + vt[i].err_inc;
         chk($sformatf("vec%0d count", i), nout, vt[i].nexp);
         for (int k = 0; k < vt[i].nexp; k++) begin
            chk($sformatf("vec%0d word%0d", i, k), outw[k], vt[i].e[k]);
         end
         chk_counters($sformatf("vec%0d", i));
         chk($sformatf("vec%0d busy", i), busy, 0);
      end

      // Pop-to-write latency on board 3, then rr_ptr=4 picks board 4 over board 3
      nout = 0;
      push(3, w(1, 'hA)); push(3, w(0, 'h1)); push(3, w(0, 'h2)); push(3, w(1, 'hF));
      drive();
      lat_mon = 1'b1;
      run_idle("lat");
      lat_mon = 1'b0;
      exp_ev++;
      chk("lat pops", lat_pops, 4);
      chk("lat errs", lat_err, 0);
      chk("lat last", outw[3], w(1, 'hF));
      nout = 0;
      push(3, w(1, 'h30)); push(3, w(1, 'h3F));
      push(4, w(1, 'h40)); push(4, w(1, 'h4F));
      drive();
      run_idle("rr4");
      exp_ev += 2;
      chk("rr4 w0", outw[0], w(1, 'h40));
      chk("rr4 w1", outw[1], w(1, 'h4F));
      chk("rr4 w2", outw[2], w(1, 'h30));
      chk("rr4 w3", outw[3], w(1, 'h3F));
      chk_counters("rr4");

      // Boards 0 and 13 released together after reset: board 0 first, no interleave
      clear_fifos();
      hold = '1;
      push(0, w(1, 'h100));  push(0, w(0, 'h101));  push(0, w(1, 'h10F));
      push(13, w(1, 'hD00)); push(13, w(0, 'hD01)); push(13, w(1, 'hD0F));
      drive();
      do_reset();
      hold = '0;
      drive();
      nout = 0;
      run_idle("b0b13");
      exp_ev = 2;
      chk("b0b13 count", nout, 6);
      chk("b0b13 w0", outw[0], w(1, 'h100));
      chk("b0b13 w2", outw[2], w(1, 'h10F));
      chk("b0b13 w3", outw[3], w(1, 'hD00));
      chk("b0b13 w5", outw[5], w(1, 'hD0F));
      chk("b0b13 lock", first_pop[13] > last_pop[0], 1);
      chk_counters("b0b13");

      // rr_ptr=13 after a board 12 event: grant 13 then wrap to 0
      push(12, w(1, 'hC0)); push(12, w(1, 'hCF));
      drive();
      run_idle("b12");
      nout = 0;
      push(0, w(1, 'hA0));   push(0, w(1, 'hAF));
      push(13, w(1, 'hDA0)); push(13, w(1, 'hDAF));
      drive();
      run_idle("wrap");
      exp_ev += 3;
      chk("wrap w0", outw[0], w(1, 'hDA0));
      chk("wrap w1", outw[1], w(1, 'hDAF));
      chk("wrap w2", outw[2], w(1, 'hA0));
      chk("wrap w3", outw[3], w(1, 'hAF));
      chk_counters("wrap");

      // Backpressure mid-body, with FIFO refill and almost_full release on the same cycle
      nout = 0;
      lat_err  = 0;
      lat_pops = 0;
      push(6, w(1, 'h600)); push(6, w(0, 'h601)); push(6, w(0, 'h602));
      push(6, w(0, 'h603)); push(6, w(0, 'h604)); push(6, w(1, 'h60F));
      drive();
      lat_mon = 1'b1;
      step();
      step();
      step();
      afull = 1'b1;
      for (int k = 0; k < 10; k++) begin
         if (k == 5) begin
            hold[6] = 1'b1;
            drive();
         end
         step();
         if (ren_s != '0 || out_wren) bp_viol++;
      end
      afull   = 1'b0;
      hold[6] = 1'b0;
      drive();
      step();
      chk("bp resume", ren_s[6], 1);
      run_idle("bp");
      lat_mon = 1'b0;
      exp_ev++;
      chk("bp stall", bp_viol, 0);
      chk("bp lat", lat_err, 0);
      chk("bp count", nout, 6);
      chk("bp w1", outw[1], w(0, 'h601));
      chk("bp w2", outw[2], w(0, 'h602));
      chk("bp w5", outw[5], w(1, 'h60F));
      chk_counters("bp");

      // Reset after the header of a 5-word event: no footer ever written
      nout = 0;
      push(9, w(1, 'h900)); push(9, w(0, 'h901)); push(9, w(0, 'h902));
      push(9, w(0, 'h903)); push(9, w(1, 'h90F));
      drive();
      step();
      step();
      chk("mid hdr", nout, 1);
      srst = 1'b1;
      step();
      chk("mid ren", ren_s, 0);
      chk("mid wren", out_wren, 0);
      chk("mid data", out_data, 0);
      chk("mid busy", busy, 0);
      exp_ev  = 0;
      exp_err = 0;
      chk_counters("mid");
      srst  = 1'b0;
      rd[9] = wr[9];
      drive();
      for (int k = 0; k < 10; k++) step();
      chk("mid nofooter", nout, 1);
      chk("mid ev after", events_merged, 0);

`ifdef B2B_MERGE_TIMEOUT_EN
      // Starved event closed by the synthetic footer
      nout = 0;
      push(2, w(1, 'h200)); push(2, w(0, 'h201));
      drive();
      for (int k = 0; k < 80 && nout < 3; k++) step();
      step();
      exp_ev++;
      exp_err++;
      chk("to count", nout, 3);
      chk("to footer", outw[2], {1'b1, 8'hEE, 56'h0});
      chk("to busy", busy, 0);
      chk_counters("to");
`endif

      chk("ren legal", ren_viol, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
